// File: rtl/if_fetch_stage_if.sv
// Bundle of the fetch stage's redirect, decode-handshake and instruction-SRAM signals.
// The fetch stage connects through master; the decode/SRAM side uses slave.
interface if_fetch_stage_if #(
  parameter int ADDR_W = 32
);
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              ds_allowin;
  logic              inst_sram_en;
  logic              inst_sram_we;
  logic [ADDR_W-1:0] inst_sram_addr;
  logic [ADDR_W-1:0] inst_sram_wdata;
  logic [ADDR_W-1:0] inst_sram_rdata;
  logic              fs_to_ds_valid;
  logic [ADDR_W-1:0] fs_to_ds_pc;
  logic [ADDR_W-1:0] fs_to_ds_inst;

  modport master (
    input  br_taken, br_target, ds_allowin, inst_sram_rdata,
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output fs_to_ds_valid, fs_to_ds_pc, fs_to_ds_inst
  );

  modport slave (
    output br_taken, br_target, ds_allowin, inst_sram_rdata,
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  fs_to_ds_valid, fs_to_ds_pc, fs_to_ds_inst
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: issues SRAM reads against buffer credit and queues
// {pc, inst} pairs in a circular buffer that decode drains at its own pace.
module if_fetch_stage #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h1c000000,
  parameter int                BUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  if_fetch_stage_if.master bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [ADDR_W-1:0] entry_pc_q   [BUF_DEPTH];
  logic [ADDR_W-1:0] entry_inst_q [BUF_DEPTH];

  logic              issue, push, pop, valid;
  logic [ADDR_W-1:0] br_addr, fetch_addr;

  // Credit counts outstanding requests too, so a response always finds a free slot.
  assign issue      = !reset && (bus.br_taken || (count_q + CNT_W'(inflight_q) < DEPTH_C));
  assign br_addr    = bus.br_target & ~ADDR_W'(3);
  assign fetch_addr = bus.br_taken ? br_addr : pc_q;
  assign push       = inflight_q && !bus.br_taken;
  assign valid      = !reset && (count_q != '0) && !bus.br_taken;
  assign pop        = valid && bus.ds_allowin;

  assign bus.inst_sram_en    = issue;
  assign bus.inst_sram_we    = 1'b0;
  assign bus.inst_sram_addr  = fetch_addr;
  assign bus.inst_sram_wdata = '0;
  assign bus.fs_to_ds_valid  = valid;
  assign bus.fs_to_ds_pc     = entry_pc_q[head_q];
  assign bus.fs_to_ds_inst   = entry_inst_q[head_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    if (issue) begin
      pc_d          = fetch_addr + ADDR_W'(4);
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_addr;
    end

    if (bus.br_taken) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // NOTE: buffer storage has no reset; count gates validity, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      entry_pc_q[tail_q]   <= inflight_pc_q;
      entry_inst_q[tail_q] <= bus.inst_sram_rdata;
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed test of if_fetch_stage: latency, stall/full, redirect, reset, PC wrap,
// plus a second instance with RESET_PC=0 and an 8-entry buffer.
module tb_if_fetch_stage;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  if_fetch_stage_if #(.ADDR_W(32)) bus1 ();
  if_fetch_stage_if #(.ADDR_W(32)) bus2 ();

  if_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h1c000000), .BUF_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  if_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h00000000), .BUF_DEPTH(8)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hdeadbeef;
  endfunction

  // Sequential SRAM models: data returns exactly one cycle after the request.
  always @(posedge clk) if (bus1.inst_sram_en) bus1.inst_sram_rdata <= inst_of(bus1.inst_sram_addr);
  always @(posedge clk) if (bus2.inst_sram_en) bus2.inst_sram_rdata <= inst_of(bus2.inst_sram_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next(input logic rst, input logic allow, input logic br, input logic [31:0] tgt);
    @(negedge clk);
    reset           = rst;
    bus1.ds_allowin = allow;
    bus1.br_taken   = br;
    bus1.br_target  = tgt;
    #1;
  endtask

  task automatic chk_req(input string tag, input logic en, input logic [31:0] addr);
    check({tag, "_en"}, 32'(bus1.inst_sram_en), 32'(en));
    if (en) check({tag, "_addr"}, bus1.inst_sram_addr, addr);
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(bus1.fs_to_ds_valid), 32'(v));
    if (v) begin
      check({tag, "_pc"}, bus1.fs_to_ds_pc, pc);
      check({tag, "_inst"}, bus1.fs_to_ds_inst, inst_of(pc));
    end
  endtask

  task automatic do_reset(input logic allow);
    next(1'b1, allow, 1'b0, 32'h0);
    chk_req("rst", 1'b0, 32'h0);
    chk_head("rst", 1'b0, 32'h0);
  endtask

  localparam logic [31:0] RP = 32'h1c000000;

  initial begin
    reset = 1'b1;
    bus1.ds_allowin = 1'b1; bus1.br_taken = 1'b0; bus1.br_target = '0;
    bus2.ds_allowin = 1'b0; bus2.br_taken = 1'b0; bus2.br_target = '0;
    bus2.inst_sram_rdata = '0; bus1.inst_sram_rdata = '0;

    // Reset holds everything idle, even with a redirect requested.
    next(1'b1, 1'b1, 1'b0, 32'h0);
    next(1'b1, 1'b1, 1'b1, 32'h1c000040);
    chk_req("rst_br", 1'b0, 32'h0);
    chk_head("rst_br", 1'b0, 32'h0);
    check("rst_we", 32'(bus1.inst_sram_we), 32'h0);
    check("rst_wdata", bus1.inst_sram_wdata, 32'h0);

    // Sequential fetch with decode always ready.
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_req("seq_c0", 1'b1, RP);        chk_head("seq_c0", 1'b0, 0);
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_req("seq_c1", 1'b1, RP + 4);    chk_head("seq_c1", 1'b0, 0);
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_req("seq_c2", 1'b1, RP + 8);    chk_head("seq_c2", 1'b1, RP);
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_head("seq_c3", 1'b1, RP + 4);
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_head("seq_c4", 1'b1, RP + 8);
    check("seq_c4_we", 32'(bus1.inst_sram_we), 32'h0);

    // Decode stalled: four requests fill the buffer, then fetch stops.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      next(1'b0, 1'b0, 1'b0, 32'h0);
      chk_req($sformatf("stall_c%0d", i), 1'b1, RP + 32'(4 * i));
      if (i >= 2) chk_head($sformatf("stall_c%0d", i), 1'b1, RP);
    end
    for (int i = 4; i < 8; i++) begin
      next(1'b0, 1'b0, 1'b0, 32'h0);
      chk_req($sformatf("stall_c%0d", i), 1'b0, 32'h0);
      chk_head($sformatf("stall_c%0d", i), 1'b1, RP);
    end
    // Drain: the pop cycle earns no credit, then fetch resumes.
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_head("drain_c8", 1'b1, RP);      chk_req("drain_c8", 1'b0, 0);
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_head("drain_c9", 1'b1, RP + 4);  chk_req("drain_c9", 1'b1, RP + 16);
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_head("drain_c10", 1'b1, RP + 8); chk_req("drain_c10", 1'b1, RP + 20);
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_head("drain_c11", 1'b1, RP + 12);
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_head("drain_c12", 1'b1, RP + 16);
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_head("drain_c13", 1'b1, RP + 20);

    // Full buffer then a one-cycle reset pulse.
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) next(1'b0, 1'b0, 1'b0, 32'h0);
    chk_head("full", 1'b1, RP);
    next(1'b1, 1'b0, 1'b0, 32'h0);
    chk_req("pulse", 1'b0, 0); chk_head("pulse", 1'b0, 0);
    // Simultaneous push and pop at count=3, inflight=1.
    next(1'b0, 1'b0, 1'b0, 32'h0); chk_req("post_c0", 1'b1, RP); chk_head("post_c0", 1'b0, 0);
    next(1'b0, 1'b0, 1'b0, 32'h0);
    next(1'b0, 1'b0, 1'b0, 32'h0);
    next(1'b0, 1'b0, 1'b0, 32'h0); chk_req("pp_c3", 1'b1, RP + 12);
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_req("pp_c4", 1'b0, 0);  chk_head("pp_c4", 1'b1, RP);
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_req("pp_c5", 1'b1, RP + 16); chk_head("pp_c5", 1'b1, RP + 4);
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_head("pp_c6", 1'b1, RP + 8);
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_head("pp_c7", 1'b1, RP + 12);
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_head("pp_c8", 1'b1, RP + 16);

    // Redirect with two entries buffered and one response in flight.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) next(1'b0, 1'b0, 1'b0, 32'h0);
    chk_head("pre_br", 1'b1, RP);
    next(1'b0, 1'b0, 1'b1, 32'h1c000103);
    chk_req("br_c3", 1'b1, 32'h1c000100); chk_head("br_c3", 1'b0, 0);
    next(1'b0, 1'b0, 1'b0, 32'h0); chk_req("br_c4", 1'b1, 32'h1c000104); chk_head("br_c4", 1'b0, 0);
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_head("br_c5", 1'b1, 32'h1c000100);
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_head("br_c6", 1'b1, 32'h1c000104);
    // Redirect to the top of the address space: PC wraps to 0.
    next(1'b0, 1'b1, 1'b1, 32'hfffffffe);
    chk_req("wrap_c7", 1'b1, 32'hfffffffc); chk_head("wrap_c7", 1'b0, 0);
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_req("wrap_c8", 1'b1, 32'h0); chk_head("wrap_c8", 1'b0, 0);
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_req("wrap_c9", 1'b1, 32'h4); chk_head("wrap_c9", 1'b1, 32'hfffffffc);
    next(1'b0, 1'b1, 1'b0, 32'h0); chk_head("wrap_c10", 1'b1, 32'h0);

    // Second instance: RESET_PC=0, 8 entries, decode never ready.
    do_reset(1'b1);
    check("d2_rst_en", 32'(bus2.inst_sram_en), 32'h0);
    for (int i = 0; i < 11; i++) begin
      next(1'b0, 1'b1, 1'b0, 32'h0);
      check($sformatf("d2_c%0d_en", i), 32'(bus2.inst_sram_en), (i < 8) ? 32'h1 : 32'h0);
      if (i < 8) check($sformatf("d2_c%0d_addr", i), bus2.inst_sram_addr, 32'(4 * i));
      if (i >= 2) begin
        check($sformatf("d2_c%0d_valid", i), 32'(bus2.fs_to_ds_valid), 32'h1);
        check($sformatf("d2_c%0d_pc", i), bus2.fs_to_ds_pc, 32'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter ADDR_W, default 32: width of PC, instruction-SRAM address and data.
REQ-002 Parameter RESET_PC, default 32'h1c000000: first fetch address after reset.
REQ-003 Parameter BUF_DEPTH, default 4: instruction buffer entries; legal values 4, 8, 16.
REQ-004 Port clk  in  1: the only clock; all state updates on its rising edge.
REQ-005 Port reset  in  1: synchronous, active-high reset.
REQ-006 Port br_taken  in  1: redirect request from decode.
REQ-007 Port br_target  in  ADDR_W: redirect address; bits [1:0] ignored and treated as 00.
REQ-008 Port ds_allowin  in  1: decode accepts an instruction this cycle.
REQ-009 Port inst_sram_en  out  1: read request strobe.
REQ-010 Port inst_sram_we  out  1: tied 0.
REQ-011 Port inst_sram_addr  out  ADDR_W: request address.
REQ-012 Port inst_sram_wdata  out  ADDR_W: tied 0.
REQ-013 Port inst_sram_rdata  in  ADDR_W: read data, valid exactly one cycle after the request.
REQ-014 Port fs_to_ds_valid  out  1: buffer head holds a valid instruction.
REQ-015 Port fs_to_ds_pc  out  ADDR_W: PC of buffer head.
REQ-016 Port fs_to_ds_inst  out  ADDR_W: instruction word of buffer head.

Function
REQ-017 State: pc (next fetch address), inflight bit with inflight_pc, circular buffer of BUF_DEPTH {pc, inst} entries, head/tail pointers, count of width clog2(BUF_DEPTH)+1.
REQ-018 Issue rule: inst_sram_en = !reset && (br_taken || count + inflight < BUF_DEPTH), using registered count; a same-cycle pop earns no credit.
REQ-019 Address: inst_sram_addr = br_taken ? {br_target[ADDR_W-1:2],2'b00} : pc; on issue pc <= inst_sram_addr + 4, inflight <= 1, inflight_pc <= inst_sram_addr; no issue: inflight <= 0.
REQ-020 Response: in a cycle with inflight=1 and br_taken=0, {inflight_pc, inst_sram_rdata} is written at tail; tail increments modulo BUF_DEPTH.
REQ-021 Pop: fs_to_ds_valid && ds_allowin advances head modulo BUF_DEPTH.
REQ-022 Simultaneous push and pop: count unchanged; both pointers advance.
REQ-023 fs_to_ds_valid = (count != 0) && !br_taken; fs_to_ds_pc/inst come directly from the head entry with no added latency.
REQ-024 Redirect (br_taken=1): count, head, tail cleared to 0; any response arriving that cycle is discarded; no pop occurs; the request to br_target issues the same cycle.
REQ-025 Latency: request at cycle t yields fs_to_ds_valid at t+2 at the earliest.
REQ-026 Throughput: with ds_allowin held 1 and no redirect, one instruction per cycle sustained (count<=1, inflight=1).
REQ-027 Full: count + inflight = BUF_DEPTH blocks issue; count never exceeds BUF_DEPTH; no entry is ever overwritten.
REQ-028 Empty: fs_to_ds_valid=0; the head contents are don't-care.
REQ-029 PC wraps modulo 2^ADDR_W; no fault detection.

Reset
REQ-030 While reset=1: inst_sram_en=0, fs_to_ds_valid=0, count=0, head=tail=0, inflight=0, pc=RESET_PC; br_taken is ignored.
REQ-031 Reset asserted mid-operation discards all buffered and in-flight instructions on the next edge.
REQ-032 First cycle with reset=0: request to RESET_PC.

Verification
REQ-033 Reset release, ds_allowin=1, sequential SRAM: requests 0x1c000000 at c0, 0x1c000004 at c1; fs_to_ds_valid=1 from c2 with pc 0x1c000000, then +4 every cycle.
REQ-034 ds_allowin=0 from reset: exactly 4 requests (c0-c3), inst_sram_en=0 thereafter, head stays pc 0x1c000000 with stable inst; raising ds_allowin drains 4 in order and resumes fetch.
REQ-035 br_taken=1, br_target=0x1c000103 while a response is in flight and 2 entries buffered: same-cycle addr 0x1c000100, fs_to_ds_valid=0 that cycle, in-flight response dropped, next valid pc 0x1c000100 two cycles later.
REQ-036 count=3, inflight=1, pop and push together: count stays 3, order preserved, no issue that cycle.
REQ-037 reset pulsed for 1 cycle with buffer full: fs_to_ds_valid=0 next cycle, first request after reset is RESET_PC.
REQ-038 RESET_PC=0, BUF_DEPTH=8, ds_allowin=0: 8 requests 0x0..0x1c, then stall.
